// File: rtl/cacheline_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cacheline_mem_arbiter
//
// Shares one line-wide downstream memory port (dfp) between the instruction-side
// line buffer (read-only) and the data cache (read/write). One line request is
// accepted at a time. Its address and write data are latched, and the dfp request
// is held until dfp_resp. The returned line then goes to the owning requester
// together with a one-cycle response pulse. Every output comes from a flop.
//
// Optional feature: define MEM_ARB_RR_EN to select round-robin arbitration on
// simultaneous requests. When it is undefined, the D side has fixed priority.
//
// State table:
//   state   | meaning
//   IDLE    | sample imem/dmem requests each edge and grant one
//   SERVE_I | dfp read in flight on behalf of the I side
//   SERVE_D | dfp read or write in flight on behalf of the D side
//   RESP    | one-cycle response pulse to the owner, then back to IDLE
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   imem_read/addr         I-side line read request (held until imem_resp)
//   imem_rdata/resp        returned line and one-cycle completion pulse
//   dmem_read/write/addr   D-side line request (held until dmem_resp)
//   dmem_wdata             D-side writeback line
//   dmem_rdata/resp        returned line and one-cycle completion pulse
//   dfp_addr               downstream line address (offset bits forced to 0)
//   dfp_read/write/wdata   downstream request, held until dfp_resp
//   dfp_rdata/resp         downstream read data and completion
//   arb_busy               high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module cacheline_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_read,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [LINE_WIDTH-1:0] imem_rdata,
    output logic                  imem_resp,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [LINE_WIDTH-1:0] dmem_wdata,
    output logic [LINE_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_resp,
    output logic [ADDR_WIDTH-1:0] dfp_addr,
    output logic                  dfp_read,
    output logic                  dfp_write,
    output logic [LINE_WIDTH-1:0] dfp_wdata,
    input  logic [LINE_WIDTH-1:0] dfp_rdata,
    input  logic                  dfp_resp,
    output logic                  arb_busy
);

    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] dfp_addr_q,   dfp_addr_d;
    logic [LINE_WIDTH-1:0] dfp_wdata_q,  dfp_wdata_d;
    logic                  dfp_read_q,   dfp_read_d;
    logic                  dfp_write_q,  dfp_write_d;
    logic [LINE_WIDTH-1:0] imem_rdata_q, imem_rdata_d;
    logic [LINE_WIDTH-1:0] dmem_rdata_q, dmem_rdata_d;
    logic                  imem_resp_q,  imem_resp_d;
    logic                  dmem_resp_q,  dmem_resp_d;
    logic                  arb_busy_q,   arb_busy_d;

    logic d_req;
    logic i_req;
    logic pick_d;

    assign d_req = dmem_read | dmem_write;
    assign i_req = imem_read;

`ifdef MEM_ARB_RR_EN
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic last_grant_q, last_grant_d;

    // On a conflict, serve the side that did not win the previous grant.
    always_comb begin
        if (d_req && i_req) begin
            pick_d = (last_grant_q == GRANT_I);
        end else begin
            pick_d = d_req;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (d_req || i_req)) begin
            last_grant_d = pick_d ? GRANT_D : GRANT_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_comb begin
        state_d      = state_q;
        dfp_addr_d   = dfp_addr_q;
        dfp_wdata_d  = dfp_wdata_q;
        dfp_read_d   = dfp_read_q;
        dfp_write_d  = dfp_write_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        imem_resp_d  = 1'b0;
        dmem_resp_d  = 1'b0;
        arb_busy_d   = arb_busy_q;

        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    arb_busy_d = 1'b1;
                    if (pick_d) begin
                        state_d     = SERVE_D;
                        dfp_addr_d  = {dmem_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        dfp_wdata_d = dmem_wdata;
                        dfp_write_d = dmem_write;
                        dfp_read_d  = ~dmem_write;
                    end else begin
                        state_d     = SERVE_I;
                        dfp_addr_d  = {imem_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        dfp_write_d = 1'b0;
                        dfp_read_d  = 1'b1;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (dfp_resp) begin
                    state_d     = RESP;
                    dfp_read_d  = 1'b0;
                    dfp_write_d = 1'b0;
                    // The response flop is set here so the pulse lines up with RESP.
                    if (state_q == SERVE_I) begin
                        imem_rdata_d = dfp_rdata;
                        imem_resp_d  = 1'b1;
                    end else begin
                        dmem_rdata_d = dfp_rdata;
                        dmem_resp_d  = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d    = IDLE;
                arb_busy_d = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                arb_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dfp_addr_q   <= '0;
            dfp_wdata_q  <= '0;
            dfp_read_q   <= 1'b0;
            dfp_write_q  <= 1'b0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            imem_resp_q  <= 1'b0;
            dmem_resp_q  <= 1'b0;
            arb_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dfp_addr_q   <= dfp_addr_d;
            dfp_wdata_q  <= dfp_wdata_d;
            dfp_read_q   <= dfp_read_d;
            dfp_write_q  <= dfp_write_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            imem_resp_q  <= imem_resp_d;
            dmem_resp_q  <= dmem_resp_d;
            arb_busy_q   <= arb_busy_d;
        end
    end

    assign dfp_addr   = dfp_addr_q;
    assign dfp_wdata  = dfp_wdata_q;
    assign dfp_read   = dfp_read_q;
    assign dfp_write  = dfp_write_q;
    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;
    assign imem_resp  = imem_resp_q;
    assign dmem_resp  = dmem_resp_q;
    assign arb_busy   = arb_busy_q;

`ifndef SYNTHESIS
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(dmem_read && dmem_write));
    a_i_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == SERVE_I) |-> imem_read);
    a_d_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == SERVE_D) |-> (dmem_read || dmem_write));
    a_dfp_resp_in_serve: assert property (@(posedge clk) disable iff (rst)
        dfp_resp |-> (state_q == SERVE_I || state_q == SERVE_D));
`endif

endmodule
